// File: rtl/bus_arbiter.sv
// Round-robin owner of a shared bus: grants one source at a time, drives the
// active-low transceiver enables and registers the owner's data onto bus_out.
module bus_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] data_in,
  output logic [N-1:0]       grant,
  output logic [N-1:0]       oe_n,
  output logic [WIDTH-1:0]   bus_out,
  output logic               bus_valid,
  output logic               busy
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [OW-1:0] LAST_IDX  = OW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             bus_valid_q, bus_valid_d;

  // Round-robin pick: first requester at or after ptr, wrapping past N-1.
  logic          win_found;
  logic [OW-1:0] win_idx;
  logic [OW:0]   cand;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (OW+1)'(k);
      if (cand >= (OW+1)'(N)) cand = cand - (OW+1)'(N);
      if (!win_found && req[cand[OW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[OW-1:0];
      end
    end
  end

  logic [N-1:0] owner_onehot;
  logic         others_pending;
  logic         hold_at_limit;

  always_comb begin
    owner_onehot          = '0;
    owner_onehot[owner_q] = 1'b1;
    others_pending        = |(req & ~owner_onehot);
    hold_at_limit         = (hold_q == HOLD_LAST);
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = 1'b0;

    unique case (state_q)
      IDLE, TURN: begin
        // TURN re-arbitrates exactly like IDLE, so a request raised during TURN is eligible here.
        if (win_found) begin
          state_d = OWN;
          owner_d = win_idx;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        bus_out_d   = data_in[owner_q*WIDTH +: WIDTH];
        bus_valid_d = 1'b1;
        if (!hold_at_limit) hold_d = hold_q + 1'b1;
        if (!req[owner_q] || (hold_at_limit && others_pending)) begin
          state_d = TURN;
          ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  // Enables decode only registered state, so req glitches never reach the transceivers.
  always_comb begin
    grant = '0;
    if (state_q == OWN) grant[owner_q] = 1'b1;
  end

  assign oe_n      = ~grant;
  assign busy      = (state_q != IDLE);
  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural ownership model.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   data_in;
  logic [N-1:0]     grant;
  logic [N-1:0]     oe_n;
  logic [W-1:0]     bus_out;
  logic             bus_valid;
  logic             busy;

  bus_arbiter #(.N(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .oe_n      (oe_n),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: owner index (-1 when nobody owns), a pending-turnaround flag and
  // how many cycles the current owner has held the bus so far.
  int         m_owner = -1;
  bit         m_turn  = 1'b0;
  int         m_ptr   = 0;
  int         m_run   = 0;
  logic [W-1:0] m_bus = '0;
  bit         m_valid = 1'b0;

  task automatic model_edge();
    bit others;
    if (reset) begin
      m_owner = -1; m_turn = 1'b0; m_ptr = 0; m_run = 0; m_bus = '0; m_valid = 1'b0;
    end else if (m_owner >= 0) begin
      m_bus   = data_in[m_owner*W +: W];
      m_valid = 1'b1;
      m_run++;
      others = 1'b0;
      for (int i = 0; i < N; i++) if (i != m_owner && req[i]) others = 1'b1;
      if (!req[m_owner] || (m_run >= MH && others)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_turn  = 1'b1;
      end
    end else begin
      m_valid = 1'b0;
      m_turn  = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_run   = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    logic [N-1:0] eo;
    logic [N-1:0] ng;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    eo = ~eg;
    ng = ~grant;
    check("grant",     32'(grant),     32'(eg));
    check("oe_n",      32'(oe_n),      32'(eo));
    check("bus_out",   32'(bus_out),   32'(m_bus));
    check("bus_valid", 32'(bus_valid), 32'(m_valid));
    check("busy",      32'(busy),      32'((m_owner >= 0) || m_turn));
    check("oe_inv",    32'(oe_n),      32'(ng));
    check("onehot0",   32'($onehot0(grant)), 32'(1));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [N-1:0] eg;
    reset   = 1'b1;
    req     = 4'hF;
    data_in = 32'h1234_5678;

    // Reset with all requests asserted.
    repeat (2) begin
      cycle();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_oe_n",  32'(oe_n),  32'hF);
      check("rst_bus",   32'(bus_out), 32'h00);
      check("rst_valid", 32'(bus_valid), 32'h0);
      check("rst_busy",  32'(busy),  32'h0);
    end
    reset = 1'b0;
    req   = '0;
    cycle();

    // Single request from source 2.
    req = 4'b0100;
    data_in[2*W +: W] = 8'hA5;
    cycle();
    check("single_grant", 32'(grant), 32'b0100);
    cycle();
    check("single_bus",   32'(bus_out), 32'hA5);
    check("single_valid", 32'(bus_valid), 32'h1);
    repeat (2) cycle();
    req = '0;
    cycle();
    check("single_turn_grant", 32'(grant), 32'h0);
    check("single_turn_busy",  32'(busy),  32'h1);
    cycle();
    check("single_idle_busy",  32'(busy),    32'h0);
    check("single_idle_valid", 32'(bus_valid), 32'h0);
    check("single_idle_bus",   32'(bus_out), 32'hA5);

    // Full contention from a fresh reset: owners 0,1,2,3,0, MH cycles each, one gap.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req   = 4'hF;
    for (int t = 0; t < 25; t++) begin
      cycle();
      eg = '0;
      if ((t % 5) < 4) eg[(t / 5) % 4] = 1'b1;
      check("contention", 32'(grant), 32'(eg));
    end
    req = '0;
    repeat (3) cycle();

    // No contention: a lone requester is never forced through TURN.
    req = 4'b0010;
    for (int t = 0; t < 10; t++) begin
      cycle();
      check("lone_grant", 32'(grant), 32'b0010);
    end
    req = '0;
    repeat (3) cycle();

    // Reset while source 2 owns the bus; ptr must return to 0.
    req = 4'b0100;
    repeat (3) cycle();
    check("pre_reset_grant", 32'(grant), 32'b0100);
    reset = 1'b1;
    cycle();
    check("mid_reset_grant", 32'(grant), 32'h0);
    reset = 1'b0;
    req   = 4'b1010;
    cycle();
    check("post_reset_grant", 32'(grant), 32'b0010);
    req = '0;
    repeat (3) cycle();

    // Streaming data through owner 3.
    req = 4'b1000;
    data_in[3*W +: W] = 8'h01;
    cycle();
    check("stream_grant", 32'(grant), 32'b1000);
    for (int v = 1; v <= 3; v++) begin
      data_in[3*W +: W] = 8'(v);
      cycle();
      check("stream_bus", 32'(bus_out), 32'(v));
    end
    req = '0;
    repeat (3) cycle();

    // Randomized traffic with sticky requests and occasional resets.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
      data_in = N*W'($urandom);
      reset   = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
